// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte sender between NUM_REQ requesters.
// Grants in IDLE, then tracks the sender's tx_busy handshake until the frame ends or times out.
module serial_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic                          done,
    output logic                          err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                  state, state_nxt;
    logic [ID_W-1:0]         last, last_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [ID_W-1:0]         grant_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic [NUM_REQ-1:0]      ack_nxt;
    logic                    start_nxt, done_nxt, err_nxt;
    logic [ID_W:0]           pick;
    logic [ID_W-1:0]         sel;

    // Returns {found, index}: first set request after lst, wrapping around.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    lst);
        logic            found;
        logic [ID_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int              c;
            logic [ID_W-1:0] ci;
            c = int'(lst) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            ci = ID_W'(c);
            if (!found && r[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
        return {found, idx};
    endfunction

    assign pick = rr_pick(req, last);
    assign sel  = pick[ID_W-1:0];

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        grant_nxt = grant_id;
        data_nxt  = tx_data;
        ack_nxt   = '0;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pick[ID_W]) begin
                    grant_nxt = sel;
                    last_nxt  = sel;
                    data_nxt  = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
                    ack_nxt   = NUM_REQ'(1) << sel;
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                // A busy sender wins over a timeout landing on the same cycle.
                if (tx_busy) begin
                    state_nxt = WAIT;
                end else if (cnt == CNT_LIMIT) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= LAST_RST;
            cnt      <= '0;
            grant_id <= LAST_RST;
            tx_data  <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            grant_id <= grant_nxt;
            tx_data  <= data_nxt;
            ack      <= ack_nxt;
            tx_start <= start_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler: arbitration table plus hand-written
// timeout, busy-on-limit and asynchronous-reset sequences.
module tb_serial_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    serial_tx_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(8), .START_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_ack;
        logic [1:0] exp_grant;
        logic [7:0] exp_data;
        int         dly;
        int         len;
    } vec_t;

    vec_t tab[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},      32'(ack), 32'h0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
        check({tag, "_done"},     32'(done), 32'h0);
        check({tag, "_err"},      32'(err), 32'h0);
        check({tag, "_tx_data"},  32'(tx_data), 32'h0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd3);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        tx_busy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] e_ack,
                                input logic [1:0] e_grant, input logic [7:0] e_data);
        tick();
        check({tag, "_ack"},      32'(ack), 32'(e_ack));
        check({tag, "_tx_start"}, 32'(tx_start), 32'h1);
        check({tag, "_tx_data"},  32'(tx_data), 32'(e_data));
        check({tag, "_grant_id"}, 32'(grant_id), 32'(e_grant));
        check({tag, "_excl"},     32'({done, err}), 32'h0);
    endtask

    // Sender model: stays idle dly cycles after tx_start, then busy for len cycles.
    task automatic sender(input string tag, input int dly, input int len,
                          input logic [1:0] e_grant, input logic [7:0] e_data);
        int bad;
        bad = 0;
        for (int k = 0; k < dly; k++) begin
            tick();
            if (err || done || tx_start || (ack != 4'b0)) bad++;
        end
        tx_busy = 1'b1;
        for (int k = 0; k < len; k++) begin
            tick();
            if (err || done || tx_start || (ack != 4'b0)) bad++;
        end
        tx_busy = 1'b0;
        tick();
        check({tag, "_quiet"},     32'(bad), 32'h0);
        check({tag, "_done"},      32'(done), 32'h1);
        check({tag, "_done_ack"},  32'({ack, tx_start, err}), 32'h0);
        check({tag, "_hold_data"}, 32'(tx_data), 32'(e_data));
        check({tag, "_hold_gid"},  32'(grant_id), 32'(e_grant));
    endtask

    initial begin
        int bad;
        req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        rst_n    = 1'b0;
        req      = 4'b0000;
        tx_busy  = 1'b0;

        tab[0]  = '{4'b1111, 4'b0001, 2'd0, 8'hC3, 1, 10};
        tab[1]  = '{4'b1111, 4'b0010, 2'd1, 8'h5A, 1, 10};
        tab[2]  = '{4'b1111, 4'b0100, 2'd2, 8'hA5, 1, 10};
        tab[3]  = '{4'b1111, 4'b1000, 2'd3, 8'h3C, 1, 10};
        tab[4]  = '{4'b1111, 4'b0001, 2'd0, 8'hC3, 1, 10};
        tab[5]  = '{4'b1111, 4'b0010, 2'd1, 8'h5A, 1, 10};
        tab[6]  = '{4'b1001, 4'b1000, 2'd3, 8'h3C, 0, 2};
        tab[7]  = '{4'b1001, 4'b0001, 2'd0, 8'hC3, 0, 2};
        tab[8]  = '{4'b1001, 4'b1000, 2'd3, 8'h3C, 2, 1};
        tab[9]  = '{4'b0110, 4'b0010, 2'd1, 8'h5A, 5, 3};
        tab[10] = '{4'b0110, 4'b0100, 2'd2, 8'hA5, 0, 1};
        tab[11] = '{4'b0001, 4'b0001, 2'd0, 8'hC3, 3, 4};
        tab[12] = '{4'b1000, 4'b1000, 2'd3, 8'h3C, 1, 6};
        tab[13] = '{4'b0010, 4'b0010, 2'd1, 8'h5A, 4, 2};

        do_reset();
        check_reset_outputs("rst");
        tick();
        check_reset_outputs("rst_idle");

        // Single request from requester 2, sender busy 3 cycles after tx_start for 20 cycles.
        req = 4'b0100;
        expect_grant("t1", 4'b0100, 2'd2, 8'hA5);
        req = 4'b0000;
        sender("t1", 3, 20, 2'd2, 8'hA5);
        tick();
        check("t1_done_once", 32'(done), 32'h0);
        check("t1_hold_data2", 32'(tx_data), 32'hA5);

        // Round-robin table starting from a fresh reset.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            req = tab[i].req;
            expect_grant($sformatf("tab%0d", i), tab[i].exp_ack, tab[i].exp_grant, tab[i].exp_data);
            sender($sformatf("tab%0d", i), tab[i].dly, tab[i].len, tab[i].exp_grant, tab[i].exp_data);
        end
        req = 4'b0000;

        // Sender never goes busy: err exactly 16 cycles after tx_start, pending req served next.
        do_reset();
        req = 4'b0001;
        expect_grant("t4", 4'b0001, 2'd0, 8'hC3);
        req = 4'b0100;
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (err || done || tx_start || (ack != 4'b0)) bad++;
        end
        check("t4_no_early_err", 32'(bad), 32'h0);
        tick();
        check("t4_err", 32'(err), 32'h1);
        check("t4_err_excl", 32'({ack, tx_start, done}), 32'h0);
        expect_grant("t4_next", 4'b0100, 2'd2, 8'hA5);
        check("t4_err_once", 32'(err), 32'h0);
        req = 4'b0000;
        sender("t4_next", 2, 4, 2'd2, 8'hA5);

        // Sender goes busy on the 16th START cycle: no err, frame completes.
        req = 4'b1000;
        expect_grant("t5", 4'b1000, 2'd3, 8'h3C);
        req = 4'b0000;
        sender("t5", 15, 5, 2'd3, 8'h3C);

        // Asynchronous reset in WAIT with sender still busy.
        do_reset();
        req = 4'b0001;
        expect_grant("t6", 4'b0001, 2'd0, 8'hC3);
        tx_busy = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        req   = 4'b0010;
        expect_grant("t6_after", 4'b0010, 2'd1, 8'h5A);
        req = 4'b0000;
        sender("t6_after", 0, 3, 2'd1, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
